// File: rtl/stoch_mult_param_if.sv
// Handshake and operand bundle for stoch_mult_param; the master drives
// operands and start, the slave returns status and results.
interface stoch_mult_param_if #(
  parameter int PW       = 4,
  parameter int WIN_LOG2 = 7
);
  logic                start;
  logic [PW-1:0]       prob_a;
  logic [PW-1:0]       prob_b;
  logic                mode;
  logic                busy;
  logic                done;
  logic [WIN_LOG2:0]   result;
  logic [PW-1:0]       result_scaled;
  logic                sn_out;

  modport master (
    output start, prob_a, prob_b, mode,
    input  busy, done, result, result_scaled, sn_out
  );

  modport slave (
    input  start, prob_a, prob_b, mode,
    output busy, done, result, result_scaled, sn_out
  );
endinterface

// File: rtl/stoch_mult_param.sv
// Stochastic-computing multiplier: two free-running LFSR comparators make
// bitstreams, AND/XNOR multiplies them, a windowed counter sums the product.
module stoch_mult_param #(
  parameter int          PW       = 4,
  parameter int          WIN_LOG2 = 7,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  stoch_mult_param_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state;
  logic [30:0]         lfsr_a;
  logic [30:0]         lfsr_b;
  logic [PW-1:0]       a_lat;
  logic [PW-1:0]       b_lat;
  logic                mode_lat;
  logic [WIN_LOG2:0]   acc;
  logic [WIN_LOG2-1:0] cnt;
  logic                done;
  logic                sn_out;
  logic [WIN_LOG2:0]   result;
  logic [PW-1:0]       result_scaled;

  logic                sn_a;
  logic                sn_b;
  logic                prod;
  logic                last;
  logic [WIN_LOG2:0]   acc_next;
  logic [PW-1:0]       scaled_next;

  always_comb begin
    sn_a     = lfsr_a[PW-1:0] < a_lat;
    sn_b     = lfsr_b[PW-1:0] < b_lat;
    prod     = mode_lat ? ~(sn_a ^ sn_b) : (sn_a & sn_b);
    last     = &cnt;
    acc_next = acc + (WIN_LOG2+1)'(prod);
    // A full count saturates; below N the top PW count bits are the shifted value.
    scaled_next = acc_next[WIN_LOG2] ? '1 : acc_next[WIN_LOG2-1 -: PW];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      lfsr_a        <= SEED_A;
      lfsr_b        <= SEED_B;
      a_lat         <= '0;
      b_lat         <= '0;
      mode_lat      <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      done          <= 1'b0;
      sn_out        <= 1'b0;
      result        <= '0;
      result_scaled <= '0;
    end else begin
      lfsr_a <= {lfsr_a[29:0], lfsr_a[27] ^ lfsr_a[30]};
      lfsr_b <= {lfsr_b[29:0], lfsr_b[27] ^ lfsr_b[30]};
      done   <= 1'b0;
      sn_out <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
          if (bus.start) begin
            a_lat    <= bus.prob_a;
            b_lat    <= bus.prob_b;
            mode_lat <= bus.mode;
            state    <= RUN;
          end
        end
        default: begin
          acc <= acc_next;
          cnt <= cnt + WIN_LOG2'(1);
          if (last) begin
            result        <= acc_next;
            result_scaled <= scaled_next;
            done          <= 1'b1;
            state         <= IDLE;
          end else begin
            sn_out <= prod;
          end
        end
      endcase
    end
  end

  assign bus.busy          = (state == RUN);
  assign bus.done          = done;
  assign bus.result        = result;
  assign bus.result_scaled = result_scaled;
  assign bus.sn_out        = sn_out;

endmodule

// File: tb/tb_stoch_mult_param.sv
// Directed + random bench for stoch_mult_param at PW=4/WIN=7 and PW=6/WIN=10,
// with an LFSR reference model feeding an expected-result queue per instance.
module tb_stoch_mult_param;

  localparam logic [30:0] S0A = 31'd1;
  localparam logic [30:0] S0B = 31'd2;
  localparam logic [30:0] S1A = 31'h1234567;
  localparam logic [30:0] S1B = 31'h0abcdef;

  typedef struct {
    int res;
    int sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stoch_mult_param_if #(.PW(4), .WIN_LOG2(7))  b0 ();
  stoch_mult_param_if #(.PW(6), .WIN_LOG2(10)) b1 ();

  stoch_mult_param #(.PW(4), .WIN_LOG2(7), .SEED_A(S0A), .SEED_B(S0B)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  stoch_mult_param #(.PW(6), .WIN_LOG2(10), .SEED_A(S1A), .SEED_B(S1B)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [30:0] ma0, mb0, ma1, mb1;

  function automatic logic [30:0] step(input logic [30:0] x);
    return {x[29:0], x[27] ^ x[30]};
  endfunction

  // Reference LFSRs: reseed on reset, otherwise advance every cycle.
  always @(posedge clk) begin
    if (rst_n) begin
      ma0 <= S0A; mb0 <= S0B; ma1 <= S1A; mb1 <= S1B;
    end else begin
      ma0 <= step(ma0); mb0 <= step(mb0); ma1 <= step(ma1); mb1 <= step(mb1);
    end
  end

  task automatic model(input int pw, input int wl, input logic [30:0] la0,
                       input logic [30:0] lb0, input int a, input int b,
                       input int m, output exp_t e);
    logic [30:0] la;
    logic [30:0] lb;
    int n;
    int mask;
    int c;
    bit sa;
    bit sb;
    la = la0; lb = lb0;
    n = 1 << wl; mask = (1 << pw) - 1; c = 0;
    for (int i = 0; i < n; i++) begin
      sa = (int'(la[15:0]) & mask) < a;
      sb = (int'(lb[15:0]) & mask) < b;
      if (m != 0) c += (sa == sb) ? 1 : 0;
      else        c += (sa && sb) ? 1 : 0;
      la = step(la); lb = step(lb);
    end
    e.res = c;
    e.sc  = (c == n) ? mask : (c >> (wl - pw));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int s);
    return (s == 0) ? b0.done : b1.done;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? b0.busy : b1.busy;
  endfunction
  function automatic logic get_sn(input int s);
    return (s == 0) ? b0.sn_out : b1.sn_out;
  endfunction
  function automatic logic [31:0] get_res(input int s);
    return (s == 0) ? 32'(b0.result) : 32'(b1.result);
  endfunction
  function automatic logic [31:0] get_sc(input int s);
    return (s == 0) ? 32'(b0.result_scaled) : 32'(b1.result_scaled);
  endfunction

  // Drive a start for one edge; on return we are #1 into the first RUN cycle.
  task automatic launch(input int s, input int a, input int b, input int m);
    exp_t e;
    if (s == 0) begin
      b0.prob_a = 4'(a); b0.prob_b = 4'(b); b0.mode = m[0]; b0.start = 1'b1;
    end else begin
      b1.prob_a = 6'(a); b1.prob_b = 6'(b); b1.mode = m[0]; b1.start = 1'b1;
    end
    @(posedge clk); #1;
    b0.start = 1'b0; b1.start = 1'b0;
    if (s == 0) begin
      model(4, 7, ma0, mb0, a, b, m, e);
      q0.push_back(e);
    end else begin
      model(6, 10, ma1, mb1, a, b, m, e);
      q1.push_back(e);
    end
  endtask

  task automatic wait_done(input int s, input int exp_k, input string tag);
    int k;
    bit seen;
    exp_t e;
    seen = 1'b0;
    for (k = 1; k <= exp_k + 4; k++) begin
      @(posedge clk); #1;
      if (get_done(s)) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_latency"}, seen ? k : -1, exp_k);
    if (seen) begin
      if (s == 0 && q0.size() > 0) e = q0.pop_front();
      else if (s == 1 && q1.size() > 0) e = q1.pop_front();
      else begin e.res = -1; e.sc = -1; end
      chk({tag, "_result"}, get_res(s), e.res);
      chk({tag, "_scaled"}, get_sc(s), e.sc);
      chk({tag, "_busy_done"}, 32'(get_busy(s)), 0);
      chk({tag, "_sn_done"}, 32'(get_sn(s)), 0);
    end
  endtask

  initial begin
    int seen;
    int a;
    int b;
    int m;
    b0.start = 1'b0; b0.prob_a = '0; b0.prob_b = '0; b0.mode = 1'b0;
    b1.start = 1'b0; b1.prob_a = '0; b1.prob_b = '0; b1.mode = 1'b0;

    // Reset state
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_result", get_res(0), 0);
    chk("rst_scaled", get_sc(0), 0);
    chk("rst_sn", 32'(b0.sn_out), 0);
    rst_n = 1'b0;

    // Idle with start low: nothing moves
    seen = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (b0.busy || b0.done || b1.busy || b1.done) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Unipolar with a zero operand
    launch(0, 0, 15, 0);
    chk("run_busy", 32'(b0.busy), 1);
    wait_done(0, 128, "uni_zero");
    chk("uni_zero_const", get_res(0), 0);
    chk("uni_zero_sc_const", get_sc(0), 0);

    // Bipolar zero/zero saturates
    launch(0, 0, 0, 1);
    wait_done(0, 128, "bip_zero");
    chk("bip_zero_const", get_res(0), 128);
    chk("bip_zero_sc_const", get_sc(0), 15);

    // start during RUN is ignored
    launch(0, 3, 5, 0);
    repeat (48) @(posedge clk);
    #1;
    b0.prob_a = 4'd15; b0.prob_b = 4'd15; b0.mode = 1'b1; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    chk("ignored_busy", 32'(b0.busy), 1);
    wait_done(0, 128 - 49, "ignored");

    // Back-to-back windows: start in the done cycle
    launch(0, 7, 11, 1);
    wait_done(0, 128, "b2b_first");
    launch(0, 12, 6, 0);
    wait_done(0, 128, "b2b_second");

    // Reset mid-window aborts it
    launch(0, 9, 9, 0);
    repeat (58) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    q0.delete();
    chk("midrst_busy", 32'(b0.busy), 0);
    chk("midrst_result", get_res(0), 0);
    chk("midrst_scaled", get_sc(0), 0);
    chk("midrst_sn", 32'(b0.sn_out), 0);
    seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (b0.done) seen++;
    end
    chk("midrst_nodone", seen, 0);
    launch(0, 10, 13, 1);
    wait_done(0, 128, "after_rst");

    // Random windows against the model, PW=4/WIN=7
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      m = int'($urandom_range(0, 1));
      launch(0, a, b, m);
      wait_done(0, 128, "rnd4");
    end

    // Random windows against the model, PW=6/WIN=10
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 63));
      m = int'($urandom_range(0, 1));
      launch(1, a, b, m);
      wait_done(1, 1024, "rnd6");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
